// File: rtl/xt_keycode_fifo_if.sv
// Keycode FIFO bus: the translator capture handshake, the host-side
// valid/pop reader port, and the status/control lines.
interface xt_keycode_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  xt_irq;
    logic [7:0]            xt_keycode;
    logic                  xt_clear_keycode;
    logic                  flush;
    logic                  pop;
    logic                  data_valid;
    logic [7:0]            data_out;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  overflow_clear;

    // Environment side: translator, host reader and control.
    modport master (
        output xt_irq, xt_keycode, flush, pop, overflow_clear,
        input  xt_clear_keycode, data_valid, data_out, count, overflow
    );

    // FIFO side.
    modport slave (
        input  xt_irq, xt_keycode, flush, pop, overflow_clear,
        output xt_clear_keycode, data_valid, data_out, count, overflow
    );
endinterface

// File: rtl/xt_keycode_fifo.sv
// XT keycode FIFO: captures one code per translator irq assertion, queues
// it, and exposes the head through a valid/pop port. All flops update on
// the falling edge of clock; reset is asynchronous and active-high.
module xt_keycode_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clock,
    input  logic              reset,
    xt_keycode_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic                  clr_q, clr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            mem_q [DEPTH];

    logic push, do_pop, full, wr_en, ovf_set;

    // Next-state: handshake, push/pop bookkeeping, overflow, flush priority.
    always_comb begin
        push   = bus.xt_irq && !clr_q;
        full   = (count_q == CW'(DEPTH));
        do_pop = bus.pop && (count_q != '0);
        // A full FIFO still accepts a code when the same cycle pops the head.
        wr_en   = push && (!full || do_pop);
        ovf_set = push && full && !do_pop;

        // Acknowledge follows irq, so a held irq is captured only once;
        // it still acknowledges during flush or overflow so the translator
        // never stalls.
        clr_d      = bus.xt_irq;
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(wr_en);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(do_pop);
        count_d    = count_q + CW'(wr_en) - CW'(do_pop);
        // A coinciding clear loses to a new overflow event.
        overflow_d = ovf_set || (overflow_q && !bus.overflow_clear);

        if (bus.flush) begin
            wr_en      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            clr_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            clr_q      <= clr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(negedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.xt_keycode;
    end

    // Outputs straight from registers; head reads as zero when empty.
    always_comb begin
        bus.xt_clear_keycode = clr_q;
        bus.data_valid       = (count_q != '0);
        bus.data_out         = bus.data_valid ? mem_q[rd_ptr_q] : 8'h00;
        bus.count            = count_q;
        bus.overflow         = overflow_q;
    end
endmodule
